// File: rtl/note_scroll_sequencer_if.sv
// ---------------------------------------------------------------------------
// note_scroll_sequencer_if
//
// Purpose:
//   Bundles the control, note-ROM and playfield signals of the falling-note
//   scroll sequencer so the sequencer and its surroundings connect through
//   one port. clk and reset are kept outside the interface.
//
// Signals:
//   start       sequencer input   one-cycle pulse: begin song from address 0
//   pause       sequencer input   level: freeze frame counter and scrolling
//   rom_data    sequencer input   note ROM output word (LANES bits)
//   rom_addr    sequencer output  note ROM address (ADDR_W bits)
//   rom_rd      sequencer output  one-cycle ROM read strobe
//   new_row     sequencer output  note word to insert at playfield row 0
//   row_shift   sequencer output  one-cycle pulse: shift rows, load new_row
//   scroll_off  sequencer output  pixel offset of all rows within the pitch
//   frame_tick  sequencer output  one-cycle pulse per frame
//   running     sequencer output  song in progress
//   song_done   sequencer output  last note word has been shifted in
//
// Modports:
//   slave   the sequencer itself
//   master  whatever drives the sequencer and consumes its outputs
// ---------------------------------------------------------------------------
interface note_scroll_sequencer_if #(
  parameter int ADDR_W = 13,
  parameter int LANES  = 4
);
  logic              start;
  logic              pause;
  logic [LANES-1:0]  rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_rd;
  logic [LANES-1:0]  new_row;
  logic              row_shift;
  logic [7:0]        scroll_off;
  logic              frame_tick;
  logic              running;
  logic              song_done;

  modport slave (
    input  start,
    input  pause,
    input  rom_data,
    output rom_addr,
    output rom_rd,
    output new_row,
    output row_shift,
    output scroll_off,
    output frame_tick,
    output running,
    output song_done
  );

  modport master (
    output start,
    output pause,
    output rom_data,
    input  rom_addr,
    input  rom_rd,
    input  new_row,
    input  row_shift,
    input  scroll_off,
    input  frame_tick,
    input  running,
    input  song_done
  );
endinterface

// File: rtl/note_scroll_sequencer.sv
// ---------------------------------------------------------------------------
// note_scroll_sequencer
//
// Purpose:
//   Single-clock controller for the falling-note playfield. A frame counter
//   produces a frame_tick enable every FRAME_DIV cycles; each tick advances
//   the sub-row scroll offset by STEP pixels. When the offset would reach
//   ROW_PITCH it wraps to 0 and the next LANES-bit note word is fetched from
//   the note ROM (read latency ROM_LAT), then pushed into the playfield row
//   shift-register with a one-cycle row_shift strobe. After SONG_LEN words
//   the sequencer parks in DONE until the next start.
//
// Ports:
//   clk      in  system clock
//   reset    in  synchronous, active-high reset
//   bus      note_scroll_sequencer_if.slave
//              in : start, pause, rom_data
//              out: rom_addr, rom_rd, new_row, row_shift, scroll_off,
//                   frame_tick, running, song_done
//
// Parameters:
//   FRAME_DIV  clk cycles per frame tick (>= ROM_LAT+4 keeps ticks inside RUN)
//   ROW_PITCH  pixels between note rows, scroll wraps here (< 256)
//   STEP       pixels added per frame tick (< ROW_PITCH)
//   ADDR_W     note ROM address width
//   SONG_LEN   number of note words in the song (1..2^ADDR_W)
//   ROM_LAT    note ROM read latency in cycles (>= 1)
//   LANES      note lanes per ROM word
// ---------------------------------------------------------------------------
module note_scroll_sequencer #(
  parameter int FRAME_DIV = 1000000,
  parameter int ROW_PITCH = 20,
  parameter int STEP      = 4,
  parameter int ADDR_W    = 13,
  parameter int SONG_LEN  = 8192,
  parameter int ROM_LAT   = 2,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  note_scroll_sequencer_if.slave bus
);

  // -------------------------------------------------------------------------
  // Widths and constants
  // -------------------------------------------------------------------------
  localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int WC_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [FC_W-1:0]   FC_LAST   = FC_W'(FRAME_DIV - 1);
  localparam logic [WC_W-1:0]   WC_LAST   = WC_W'(ROM_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);

  // The scroll sum is formed one bit wider than scroll_off so that a large
  // STEP close to a large ROW_PITCH can never wrap around 8 bits before the
  // pitch comparison.
  localparam logic [8:0] PITCH_9 = 9'(ROW_PITCH);
  localparam logic [8:0] STEP_9  = 9'(STEP);

  // -------------------------------------------------------------------------
  // FSM encoding
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_FETCH = 3'd2,
    S_WAIT  = 3'd3,
    S_SHIFT = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  logic [FC_W-1:0]   r_frame_cnt;
  logic [WC_W-1:0]   r_wait_cnt;
  logic [7:0]        r_scroll;
  logic [ADDR_W-1:0] r_addr;
  logic [LANES-1:0]  r_new_row;

  // -------------------------------------------------------------------------
  // Combinational helpers
  // -------------------------------------------------------------------------
  logic       w_active;       // current state is one of the running states
  logic       w_next_active;  // next state is one of the running states
  logic       w_tick;         // frame tick this cycle
  logic       w_run_tick;     // frame tick that the scroll logic acts on
  logic [8:0] w_scroll_sum;
  logic       w_wrap;         // this tick would reach or pass ROW_PITCH
  logic       w_wait_done;    // ROM word is on rom_data this cycle
  logic       w_last_addr;    // word being shifted is the last of the song
  logic       w_start_ok;     // start is honoured only from IDLE or DONE

  // Registered-state decoded outputs
  logic w_rom_rd;
  logic w_row_shift;
  logic w_running;
  logic w_song_done;

  function automatic logic is_active(input state_t s);
    return (s == S_RUN) || (s == S_FETCH) || (s == S_WAIT) || (s == S_SHIFT);
  endfunction

  assign w_active      = is_active(r_state);
  assign w_next_active = is_active(w_state_next);

  // A tick can fire in FETCH/WAIT/SHIFT if FRAME_DIV is set too small; it is
  // still reported on frame_tick but only a tick seen in RUN moves the scroll.
  assign w_tick     = w_active && !bus.pause && (r_frame_cnt == FC_LAST);
  assign w_run_tick = w_tick && (r_state == S_RUN);

  assign w_scroll_sum = {1'b0, r_scroll} + STEP_9;
  assign w_wrap       = (w_scroll_sum >= PITCH_9);

  assign w_wait_done = (r_state == S_WAIT) && (r_wait_cnt == WC_LAST);
  assign w_last_addr = (r_addr == ADDR_LAST);
  assign w_start_ok  = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));

  // -------------------------------------------------------------------------
  // FSM process 1: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_run_tick && w_wrap) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_wait_done) begin
          w_state_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_state_next = w_last_addr ? S_DONE : S_RUN;
      end
      S_DONE: begin
        if (w_start_ok) begin
          w_state_next = S_RUN;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: state-decoded outputs
  // -------------------------------------------------------------------------
  always_comb begin
    w_rom_rd    = 1'b0;
    w_row_shift = 1'b0;
    w_running   = 1'b0;
    w_song_done = 1'b0;
    case (r_state)
      S_RUN: begin
        w_running = 1'b1;
      end
      S_FETCH: begin
        w_running = 1'b1;
        w_rom_rd  = 1'b1;
      end
      S_WAIT: begin
        w_running = 1'b1;
      end
      S_SHIFT: begin
        w_running   = 1'b1;
        w_row_shift = 1'b1;
      end
      S_DONE: begin
        w_song_done = 1'b1;
      end
      default: begin
        w_running = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Frame counter: wraps at FRAME_DIV-1, frozen by pause, and forced to 0
  // whenever the FSM is heading into IDLE or DONE so a fresh start always
  // begins a full frame.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_cnt <= '0;
    end else if (!w_next_active) begin
      r_frame_cnt <= '0;
    end else if (!bus.pause) begin
      if (r_frame_cnt == FC_LAST) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Scroll offset: advances on ticks in RUN, wraps to 0 on the row boundary.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_scroll <= 8'd0;
    end else if (w_start_ok) begin
      r_scroll <= 8'd0;
    end else if (w_run_tick) begin
      if (w_wrap) begin
        r_scroll <= 8'd0;
      end else begin
        r_scroll <= w_scroll_sum[7:0];
      end
    end
  end

  // -------------------------------------------------------------------------
  // ROM latency counter: counts WAIT cycles; rom_data is captured in the
  // last one, which is ROM_LAT cycles after the read strobe.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // -------------------------------------------------------------------------
  // ROM address: stays put through FETCH/WAIT, advances in SHIFT and wraps
  // to 0 after the last word so DONE already presents the song start.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr <= '0;
    end else if (w_start_ok) begin
      r_addr <= '0;
    end else if (r_state == S_SHIFT) begin
      if (w_last_addr) begin
        r_addr <= '0;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Note word register: holds the last fetched word until the next fetch
  // completes; only reset clears it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_new_row <= '0;
    end else if (w_wait_done) begin
      r_new_row <= bus.rom_data;
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign bus.rom_addr   = r_addr;
  assign bus.rom_rd     = w_rom_rd;
  assign bus.new_row    = r_new_row;
  assign bus.row_shift  = w_row_shift;
  assign bus.scroll_off = r_scroll;
  assign bus.frame_tick = w_tick;
  assign bus.running    = w_running;
  assign bus.song_done  = w_song_done;

endmodule
